// File: rtl/kf_iter_sequencer.sv
// kf_iter_sequencer: iteration sequencer for the Kalman filter stages (INIT->SP->CKG->SCU->SCO per iteration)
// Ports: clk/rst_n (async active-low), start (edge), abort (sync level), iter_cfg, mdi_valid,
//   sp/ckg/sco_done, scu_done_s/p in; en_init/sp/ckg/scu/sco, busy, iter_idx, skip_cnt,
//   iter_done_pulse, filter_done, end_valid, timeout_err, err_stage out.
module kf_iter_sequencer #(
  parameter int MAX_ITER        = 10,
  parameter int ITER_W          = $clog2(MAX_ITER + 1),
  parameter int INIT_DELAY      = 10,
  parameter int END_DELAY       = 10,
  parameter int MDI_WAIT_CYCLES = 0,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] iter_cfg,
  input  logic              mdi_valid,
  input  logic              sp_done,
  input  logic              ckg_done,
  input  logic              sco_done,
  input  logic              scu_done_s,
  input  logic              scu_done_p,
  output logic              en_init,
  output logic              en_sp,
  output logic              en_ckg,
  output logic              en_scu,
  output logic              en_sco,
  output logic              busy,
  output logic [ITER_W-1:0] iter_idx,
  output logic [ITER_W-1:0] skip_cnt,
  output logic              iter_done_pulse,
  output logic              filter_done,
  output logic              end_valid,
  output logic              timeout_err,
  output logic [2:0]        err_stage
);
  localparam int INIT_N = INIT_DELAY > 0 ? INIT_DELAY : 1;
  localparam int END_N  = END_DELAY > 0 ? END_DELAY : 1;
  localparam int LIM_A  = INIT_N > END_N ? INIT_N : END_N;
  localparam int LIM_B  = MDI_WAIT_CYCLES > TIMEOUT_CYCLES ? MDI_WAIT_CYCLES : TIMEOUT_CYCLES;
  localparam int LIM    = LIM_A > LIM_B ? LIM_A : LIM_B;
  localparam int CW     = $clog2(LIM + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_N - 1);
  localparam logic [CW-1:0] END_LAST  = CW'(END_N - 1);
  localparam logic [CW-1:0] MDI_LAST  = CW'(MDI_WAIT_CYCLES > 0 ? MDI_WAIT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic          MDI_EN    = MDI_WAIT_CYCLES > 0;
  localparam logic          WD_EN     = TIMEOUT_CYCLES > 0;
  localparam logic [ITER_W-1:0] MAX_V = ITER_W'(MAX_ITER);
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT, S_SP, S_CKG, S_SCU, S_SCO, S_LAST, S_DONE, S_ERR
  } state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [ITER_W-1:0] n_iter;
  logic start_d, skip, got_s, got_p, entered;
  logic start_edge, scu_both, wd, mdi_to, last_iter;
  assign start_edge = start & ~start_d;
  assign scu_both   = (got_s | scu_done_s) & (got_p | scu_done_p);
  assign wd         = WD_EN & (cnt == TO_LAST);
  assign mdi_to     = MDI_EN & (cnt == MDI_LAST);
  assign last_iter  = iter_idx == n_iter - ITER_W'(1);
  always_comb begin
    state_nx = state;
    if (abort) state_nx = S_IDLE;
    else
      case (state)
        S_IDLE: state_nx = start_edge ? S_INIT : S_IDLE;
        S_INIT: state_nx = cnt == INIT_LAST ? S_WAIT : S_INIT;
        S_WAIT: state_nx = mdi_valid | mdi_to ? S_SP : S_WAIT;
        S_SP:   state_nx = sp_done ? (skip ? S_SCO : S_CKG) : wd ? S_ERR : S_SP;
        S_CKG:  state_nx = ckg_done ? S_SCU : wd ? S_ERR : S_CKG;
        S_SCU:  state_nx = scu_both ? S_SCO : wd ? S_ERR : S_SCU;
        S_SCO:  state_nx = sco_done ? (last_iter ? S_LAST : S_WAIT) : wd ? S_ERR : S_SCO;
        S_LAST: state_nx = cnt == END_LAST ? S_DONE : S_LAST;
        S_DONE: state_nx = S_IDLE;
        S_ERR:  state_nx = S_ERR;
        default: state_nx = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_d     <= 1'b0;
      cnt         <= '0;
      entered     <= 1'b0;
      n_iter      <= '0;
      iter_idx    <= '0;
      skip_cnt    <= '0;
      skip        <= 1'b0;
      got_s       <= 1'b0;
      got_p       <= 1'b0;
      end_valid   <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      start_d <= start;
      entered <= state_nx != state;
      cnt     <= state_nx != state ? '0 : cnt + CW'(cnt != '1);
      if (abort) begin
        end_valid   <= 1'b0;
        timeout_err <= 1'b0;
        err_stage   <= '0;
        got_s       <= 1'b0;
        got_p       <= 1'b0;
      end else begin
        if (state == S_IDLE && start_edge) begin
          n_iter      <= iter_cfg == '0 || iter_cfg > MAX_V ? MAX_V : iter_cfg;
          iter_idx    <= '0;
          skip_cnt    <= '0;
          end_valid   <= 1'b0;
          timeout_err <= 1'b0;
          err_stage   <= '0;
        end
        if (state == S_WAIT && (mdi_valid | mdi_to)) begin
          skip <= ~mdi_valid;
          if (!mdi_valid && skip_cnt != '1) skip_cnt <= skip_cnt + ITER_W'(1);
        end
        if (state == S_SCU) begin
          got_s <= ~scu_both & (got_s | scu_done_s);
          got_p <= ~scu_both & (got_p | scu_done_p);
        end
        if (state == S_SCO && sco_done && !last_iter) iter_idx <= iter_idx + ITER_W'(1);
        if (state == S_LAST && state_nx == S_DONE) end_valid <= 1'b1;
        if (state_nx == S_ERR && state != S_ERR) begin
          timeout_err <= 1'b1;
          err_stage   <= state == S_SP ? 3'd1 : state == S_CKG ? 3'd2 : state == S_SCU ? 3'd3 : 3'd4;
        end
      end
    end
  assign en_init         = state == S_INIT;
  assign en_sp           = state == S_SP;
  assign en_ckg          = state == S_CKG;
  assign en_scu          = state == S_SCU;
  assign en_sco          = state == S_SCO;
  assign busy            = state != S_IDLE && state != S_ERR && state != S_DONE;
  assign iter_done_pulse = en_sco & entered;
  assign filter_done     = state == S_DONE;
endmodule

// File: tb/tb_kf_iter_sequencer.sv
// tb_kf_iter_sequencer: scoreboard bench with a stage responder for kf_iter_sequencer
module tb_kf_iter_sequencer;
  localparam int IW = 4;
  logic clk, rst_n, start, abort, abort_m, abort_r, mdi_valid;
  logic sp_done, ckg_done, sco_done, scu_done_s, scu_done_p;
  logic [IW-1:0] iter_cfg, iter_idx, skip_cnt;
  logic en_init, en_sp, en_ckg, en_scu, en_sco, busy;
  logic iter_done_pulse, filter_done, end_valid, timeout_err;
  logic [2:0] err_stage;
  logic [20:0] outs;
  int n_chk, n_fail, cyc, done_cnt, drop_iter, age, scu_len, last_sco_cyc;
  bit ckg_hang, split_scu, stray_p, abort_at_sp, saw_full;
  logic [3:0] cur, prev;
  typedef struct {bit is_done; int idx; bit skip; int skips;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  assign abort = abort_m | abort_r;
  assign outs = {en_init, en_sp, en_ckg, en_scu, en_sco, busy, iter_idx, skip_cnt,
                 iter_done_pulse, filter_done, end_valid, timeout_err, err_stage};

  kf_iter_sequencer #(.MAX_ITER(10), .INIT_DELAY(10), .END_DELAY(10),
                      .MDI_WAIT_CYCLES(8), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .iter_cfg(iter_cfg),
    .mdi_valid(mdi_valid), .sp_done(sp_done), .ckg_done(ckg_done), .sco_done(sco_done),
    .scu_done_s(scu_done_s), .scu_done_p(scu_done_p), .en_init(en_init), .en_sp(en_sp),
    .en_ckg(en_ckg), .en_scu(en_scu), .en_sco(en_sco), .busy(busy), .iter_idx(iter_idx),
    .skip_cnt(skip_cnt), .iter_done_pulse(iter_done_pulse), .filter_done(filter_done),
    .end_valid(end_valid), .timeout_err(timeout_err), .err_stage(err_stage));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_run(input int n, input int drop);
    for (int i = 0; i < n; i++) exp_q.push_back('{0, i, i == drop, 0});
    exp_q.push_back('{1, 0, 0, drop >= 0 ? 1 : 0});
  endtask

  task automatic run_start(input logic [IW-1:0] cfg);
    int n;
    iter_cfg = cfg;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (en_init && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("init_len", n, 10);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 3000) begin
      k++;
      @(negedge clk);
    end
    if (done_cnt < target) check("done_timeout", 0, 1);
  endtask

  // Monitor/scoreboard and stage responder share one process so sampling and driving never race.
  initial begin
    done_cnt = 0; age = 0; scu_len = 0; last_sco_cyc = 0; saw_full = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (en_init) saw_full = 0;
      if (en_ckg || en_scu) saw_full = 1;
      if (iter_done_pulse) begin
        if (exp_q.size() == 0) check("sb_extra_iter", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("iter_kind", e.is_done, 0);
          check("iter_idx", iter_idx, e.idx);
          check("iter_full_path", saw_full, !e.skip);
        end
        saw_full = 0;
      end
      if (filter_done) begin
        done_cnt++;
        if (exp_q.size() == 0) check("sb_extra_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("done_kind", e.is_done, 1);
          check("done_end_valid", end_valid, 1);
          check("done_skip_cnt", skip_cnt, e.skips);
          check("end_delay", cyc - last_sco_cyc, 11);
        end
      end
      cur = {en_sp, en_ckg, en_scu, en_sco};
      if (cur != prev) begin
        if (prev == 4'b0010) scu_len = age;
        age = 1;
      end else age++;
      prev = cur;
      sp_done    = en_sp && age == 5;
      ckg_done   = en_ckg && age == 5 && !ckg_hang;
      scu_done_s = en_scu && age == (split_scu ? 2 : 5);
      scu_done_p = (en_scu && age == (split_scu ? 9 : 5)) || (stray_p && en_ckg && age == 2);
      sco_done   = en_sco && age == 5;
      abort_r    = abort_at_sp && en_sp && age == 5;
      mdi_valid  = !(drop_iter >= 0 && drop_iter == int'(iter_idx));
      if (sco_done) last_sco_cyc = cyc;
    end
  end

  initial begin
    int k;
    n_chk = 0; n_fail = 0; drop_iter = -1;
    ckg_hang = 0; split_scu = 0; stray_p = 0; abort_at_sp = 0;
    rst_n = 0; start = 0; abort_m = 0; iter_cfg = '0; mdi_valid = 1;
    sp_done = 0; ckg_done = 0; sco_done = 0; scu_done_s = 0; scu_done_p = 0; abort_r = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", outs, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_outs", outs, 0);

    push_run(3, -1);
    run_start(3);
    wait_done(1);
    @(negedge clk);
    check("basic_end_valid", end_valid, 1);
    check("basic_busy", busy, 0);
    check("basic_iter_idx", iter_idx, 2);
    check("basic_skip_cnt", skip_cnt, 0);

    push_run(10, -1);
    run_start(0);
    wait_done(2);
    @(negedge clk);
    push_run(10, -1);
    run_start(15);
    wait_done(3);
    @(negedge clk);

    drop_iter = 1;
    push_run(3, 1);
    run_start(3);
    wait_done(4);
    drop_iter = -1;
    @(negedge clk);
    check("skip_cnt_after", skip_cnt, 1);

    split_scu = 1; stray_p = 1;
    push_run(1, -1);
    run_start(1);
    wait_done(5);
    check("scu_split_len", scu_len, 9);
    split_scu = 0; stray_p = 0;
    @(negedge clk);

    ckg_hang = 1;
    run_start(2);
    k = 0;
    while (!en_ckg && k < 200) begin
      k++;
      @(negedge clk);
    end
    check("ckg_reached", en_ckg, 1);
    k = 0;
    while (!timeout_err && k < 100) begin
      k++;
      @(negedge clk);
    end
    check("wd_latency", k, 20);
    check("wd_err_stage", err_stage, 2);
    check("wd_outs", outs, {6'b0, 4'd0, 4'd0, 4'b0001, 3'd2});
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    check("err_ignores_start", outs, {6'b0, 4'd0, 4'd0, 4'b0001, 3'd2});
    abort_m = 1;
    @(negedge clk);
    abort_m = 0;
    check("abort_from_err", outs, 0);
    ckg_hang = 0;
    @(negedge clk);

    abort_at_sp = 1;
    run_start(2);
    k = 0;
    while (!abort && k < 100) begin
      k++;
      @(posedge clk);
    end
    check("abort_seen", abort, 1);
    @(negedge clk);
    abort_at_sp = 0;
    check("abort_outs", outs, 0);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (en_ckg || busy) k++;
    end
    check("abort_stays_idle", k, 0);

    exp_q.push_back('{0, 0, 0, 0});
    run_start(2);
    k = 0;
    while (!en_sco && k < 200) begin
      k++;
      @(negedge clk);
    end
    check("sco_reached", en_sco, 1);
    #2 rst_n = 0;
    #1 check("async_reset_outs", outs, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_reset_outs", outs, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
